// File: rtl/mca_cycle_master.sv
// ============================================================================
// mca_cycle_master : MCA bus master for single 8-bit I/O and POS setup cycles
// Revision 1.0
// ============================================================================
`default_nettype none

module mca_cycle_master #(
  parameter int CMD_MIN       = 3,
  parameter int CHRDY_TIMEOUT = 64
) (
  input  logic        ext_clock,
  input  logic        chreset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_setup,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_nosel,
  output logic        resp_timeout,
  output logic        adl_l,
  output logic        cmd,
  output logic        s0_w_l,
  output logic        s1_r_l,
  output logic        m_io,
  output logic        cd_setup_l,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  input  logic        cd_sfdbk,
  input  logic        cd_chrdy_l
);

  localparam int CW = $clog2(CHRDY_TIMEOUT + 1);
  localparam logic [CW-1:0] C_MIN = CW'(CMD_MIN);
  localparam logic [CW-1:0] C_TMO = CW'(CHRDY_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_ADL  = 3'd2,
    ST_CMD  = 3'd3,
    ST_END  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          setup_q, setup_d;
  logic [7:0]    rcap_q, rcap_d;
  logic          nosel_cap_q, nosel_cap_d;
  logic          tmo_cap_q, tmo_cap_d;
  logic          rvalid_q, rvalid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rnosel_q, rnosel_d;
  logic          rtmo_q, rtmo_d;

  logic          w_active;
  logic          w_cmd_exit;
  logic          w_cmd_tmo;

  always_ff @(posedge ext_clock) begin
    if (!chreset_l) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      setup_q     <= 1'b0;
      rcap_q      <= '0;
      nosel_cap_q <= 1'b0;
      tmo_cap_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rnosel_q    <= 1'b0;
      rtmo_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      setup_q     <= setup_d;
      rcap_q      <= rcap_d;
      nosel_cap_q <= nosel_cap_d;
      tmo_cap_q   <= tmo_cap_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rnosel_q    <= rnosel_d;
      rtmo_q      <= rtmo_d;
    end
  end

  // Timeout takes priority over a ready adapter on the same clock.
  assign w_cmd_tmo  = (cnt_q == C_TMO);
  assign w_cmd_exit = w_cmd_tmo || ((cnt_q >= C_MIN) && !cd_chrdy_l);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    setup_d     = setup_q;
    rcap_d      = rcap_q;
    nosel_cap_d = nosel_cap_q;
    tmo_cap_d   = tmo_cap_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    rnosel_d    = rnosel_q;
    rtmo_d      = rtmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d     = ST_ADDR;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wr_d        = req_write;
          setup_d     = req_setup;
          rcap_d      = '0;
          nosel_cap_d = 1'b0;
          tmo_cap_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        state_d = ST_ADL;
      end
      ST_ADL: begin
        state_d     = ST_CMD;
        cnt_d       = CW'(1);
        nosel_cap_d = !setup_q && !cd_sfdbk;
      end
      ST_CMD: begin
        if (w_cmd_exit) begin
          state_d   = ST_END;
          tmo_cap_d = w_cmd_tmo;
          rcap_d    = wr_q ? 8'h00 : d_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_END: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b1;
        rdata_d  = rcap_q;
        rnosel_d = nosel_cap_q;
        rtmo_d   = tmo_cap_q;
        cnt_d    = '0;
        addr_d   = '0;
        wdata_d  = '0;
        wr_d     = 1'b0;
        setup_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign w_active     = (state_q != ST_IDLE);
  assign req_ready    = (state_q == ST_IDLE) && chreset_l;
  assign resp_valid   = rvalid_q;
  assign resp_rdata   = rdata_q;
  assign resp_nosel   = rnosel_q;
  assign resp_timeout = rtmo_q;
  assign adl_l        = (state_q != ST_ADL);
  assign cmd          = (state_q != ST_CMD);
  assign s0_w_l       = !(w_active && wr_q);
  assign s1_r_l       = !(w_active && !wr_q);
  assign m_io         = !w_active;
  assign cd_setup_l   = !(w_active && setup_q);
  assign a            = addr_q;
  assign d_out        = wdata_q;
  assign d_oe         = wr_q && ((state_q == ST_ADL) || (state_q == ST_CMD) || (state_q == ST_END));

endmodule

`default_nettype wire

// File: tb/tb_mca_cycle_master.sv
// ============================================================================
// tb_mca_cycle_master : directed self-checking bench for mca_cycle_master
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mca_cycle_master;

  logic        ext_clock;
  logic        chreset_l;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_setup;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_nosel;
  logic        resp_timeout;
  logic        adl_l;
  logic        cmd;
  logic        s0_w_l;
  logic        s1_r_l;
  logic        m_io;
  logic        cd_setup_l;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        cd_sfdbk;
  logic        cd_chrdy_l;

  int n_checks = 0;
  int n_errors = 0;

  mca_cycle_master #(.CMD_MIN(3), .CHRDY_TIMEOUT(64)) dut (
    .ext_clock(ext_clock), .chreset_l(chreset_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_setup(req_setup), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_nosel(resp_nosel),
    .resp_timeout(resp_timeout), .adl_l(adl_l), .cmd(cmd), .s0_w_l(s0_w_l),
    .s1_r_l(s1_r_l), .m_io(m_io), .cd_setup_l(cd_setup_l), .a(a),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .cd_sfdbk(cd_sfdbk),
    .cd_chrdy_l(cd_chrdy_l)
  );

  initial ext_clock = 1'b0;
  always #35 ext_clock = ~ext_clock;

  // Issues one request from a negedge and records what the bus did until resp_valid.
  // Returns at the negedge where resp_valid is seen, so a following call is back-to-back.
  task automatic do_cycle(
    input  logic wr, input logic su, input logic [15:0] ad, input logic [7:0] wd,
    input  logic [7:0] din, input logic sf, input int hold, input bit keep,
    output int lat, output int ncmd, output int nadl, output int noe,
    output int nsu, output int nbad, output logic rdy0,
    output logic [7:0] rd, output logic ns, output logic to);
    lat = -1; ncmd = 0; nadl = 0; noe = 0; nsu = 0; nbad = 0;
    rd = 8'hxx; ns = 1'bx; to = 1'bx;
    rdy0 = req_ready;
    req_write = wr; req_setup = su; req_addr = ad; req_wdata = wd;
    d_in = din; cd_sfdbk = sf; cd_chrdy_l = 1'b0; req_valid = 1'b1;
    @(posedge ext_clock);
    @(negedge ext_clock);
    if (keep) begin
      req_addr = ~ad; req_wdata = ~wd; req_write = ~wr;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 1; k <= 200; k++) begin
      if (resp_valid === 1'b1) begin
        lat = k - 1; rd = resp_rdata; ns = resp_nosel; to = resp_timeout;
        if (req_ready !== 1'b1) nbad++;
        break;
      end
      if (cmd === 1'b0) ncmd++;
      if (adl_l === 1'b0) nadl++;
      if (d_oe === 1'b1) noe++;
      if (cd_setup_l === 1'b0) nsu++;
      if (m_io !== 1'b0 || a !== ad || s0_w_l !== ~wr || s1_r_l !== wr ||
          req_ready !== 1'b0 || d_out !== wd || cd_setup_l !== ~su) nbad++;
      if (cmd === 1'b0) cd_chrdy_l = (ncmd <= hold);
      @(negedge ext_clock);
    end
    req_valid = 1'b0;
    cd_chrdy_l = 1'b0;
  endtask

  task automatic test_reset;
    chreset_l = 1'b0;
    repeat (3) @(negedge ext_clock);
    n_checks++;
    if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
    n_checks++;
    if ({adl_l, cmd, s0_w_l, s1_r_l, m_io, cd_setup_l, d_oe} !== 7'b1111110 || a !== 16'h0000 || d_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_bus: got ctl=%b a=%h d=%h want 1111110/0000/00",
        {adl_l, cmd, s0_w_l, s1_r_l, m_io, cd_setup_l, d_oe}, a, d_out);
    end
    n_checks++;
    if ({resp_valid, resp_nosel, resp_timeout} !== 3'b000 || resp_rdata !== 8'h00) begin
      n_errors++; $display("FAIL reset_resp: got v/n/t=%b rd=%h want 000/00", {resp_valid, resp_nosel, resp_timeout}, resp_rdata);
    end
    chreset_l = 1'b1;
    @(negedge ext_clock);
    n_checks++;
    if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b0, 16'h0388, 8'h11, 8'hA5, 1'b1, 0, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (lat !== 6) begin n_errors++; $display("FAIL read_latency: got %0d want 6", lat); end
    n_checks++;
    if (ncmd !== 3 || nadl !== 1 || noe !== 0 || nsu !== 0) begin
      n_errors++; $display("FAIL read_strobes: got cmd=%0d adl=%0d oe=%0d su=%0d want 3/1/0/0", ncmd, nadl, noe, nsu);
    end
    n_checks++;
    if (nbad !== 0 || rdy0 !== 1'b1) begin n_errors++; $display("FAIL read_bus: got bad=%0d rdy0=%b want 0/1", nbad, rdy0); end
    n_checks++;
    if (rd !== 8'hA5 || ns !== 1'b0 || to !== 1'b0) begin
      n_errors++; $display("FAIL read_resp: got rd=%h n=%b t=%b want A5/0/0", rd, ns, to);
    end
    @(negedge ext_clock);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 8'hA5) begin
      n_errors++; $display("FAIL read_pulse: got v=%b rd=%h want 0/A5", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_write;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b1, 1'b0, 16'h0389, 8'h3C, 8'hFF, 1'b1, 0, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (lat !== 6 || ncmd !== 3 || nadl !== 1) begin
      n_errors++; $display("FAIL write_timing: got lat=%0d cmd=%0d adl=%0d want 6/3/1", lat, ncmd, nadl);
    end
    n_checks++;
    if (noe !== 5 || nbad !== 0) begin n_errors++; $display("FAIL write_oe_bus: got oe=%0d bad=%0d want 5/0", noe, nbad); end
    n_checks++;
    if (rd !== 8'h00 || ns !== 1'b0 || to !== 1'b0) begin
      n_errors++; $display("FAIL write_resp: got rd=%h n=%b t=%b want 00/0/0", rd, ns, to);
    end
    @(negedge ext_clock);
    n_checks++;
    if (d_oe !== 1'b0 || s0_w_l !== 1'b1 || m_io !== 1'b1) begin
      n_errors++; $display("FAIL write_idle: got oe=%b s0=%b mio=%b want 0/1/1", d_oe, s0_w_l, m_io);
    end
  endtask

  task automatic test_setup;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b1, 16'h0100, 8'h00, 8'hD7, 1'b0, 0, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (nsu !== 6 || nbad !== 0 || lat !== 6) begin
      n_errors++; $display("FAIL setup_strobe: got su=%0d bad=%0d lat=%0d want 6/0/6", nsu, nbad, lat);
    end
    n_checks++;
    if (rd !== 8'hD7 || ns !== 1'b0 || to !== 1'b0) begin
      n_errors++; $display("FAIL setup_resp: got rd=%h n=%b t=%b want D7/0/0", rd, ns, to);
    end
    @(negedge ext_clock);
  endtask

  task automatic test_chrdy_extend;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b0, 16'h0304, 8'h00, 8'h69, 1'b1, 10, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (ncmd !== 11 || lat !== 14 || nbad !== 0) begin
      n_errors++; $display("FAIL extend_len: got cmd=%0d lat=%0d bad=%0d want 11/14/0", ncmd, lat, nbad);
    end
    n_checks++;
    if (rd !== 8'h69 || to !== 1'b0) begin n_errors++; $display("FAIL extend_resp: got rd=%h t=%b want 69/0", rd, to); end
    @(negedge ext_clock);
  endtask

  task automatic test_timeout;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b0, 16'h0305, 8'h00, 8'h4E, 1'b1, 1000, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (ncmd !== 64 || lat !== 67 || nbad !== 0) begin
      n_errors++; $display("FAIL timeout_len: got cmd=%0d lat=%0d bad=%0d want 64/67/0", ncmd, lat, nbad);
    end
    n_checks++;
    if (to !== 1'b1 || rd !== 8'h4E || ns !== 1'b0) begin
      n_errors++; $display("FAIL timeout_resp: got t=%b rd=%h n=%b want 1/4E/0", to, rd, ns);
    end
    @(negedge ext_clock);
  endtask

  task automatic test_nosel;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b0, 16'h0300, 8'h00, 8'h5A, 1'b0, 0, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (lat !== 6 || ncmd !== 3 || nbad !== 0) begin
      n_errors++; $display("FAIL nosel_len: got lat=%0d cmd=%0d bad=%0d want 6/3/0", lat, ncmd, nbad);
    end
    n_checks++;
    if (ns !== 1'b1 || to !== 1'b0 || rd !== 8'h5A) begin
      n_errors++; $display("FAIL nosel_resp: got n=%b t=%b rd=%h want 1/0/5A", ns, to, rd);
    end
    @(negedge ext_clock);
  endtask

  task automatic test_reset_mid_cmd;
    int seen_valid;
    req_write = 1'b1; req_setup = 1'b1; req_addr = 16'h0300; req_wdata = 8'h77;
    cd_sfdbk = 1'b0; cd_chrdy_l = 1'b1; req_valid = 1'b1;
    @(posedge ext_clock);
    @(negedge ext_clock);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && cmd !== 1'b0; k++) @(negedge ext_clock);
    n_checks++;
    if (cmd !== 1'b0) begin n_errors++; $display("FAIL rstmid_reach_cmd: got cmd=%b want 0", cmd); end
    @(negedge ext_clock);
    chreset_l = 1'b0;
    @(negedge ext_clock);
    n_checks++;
    if ({adl_l, cmd, s0_w_l, s1_r_l, m_io, cd_setup_l, d_oe} !== 7'b1111110 || a !== 16'h0000 || d_out !== 8'h00) begin
      n_errors++; $display("FAIL rstmid_bus: got ctl=%b a=%h d=%h want 1111110/0000/00",
        {adl_l, cmd, s0_w_l, s1_r_l, m_io, cd_setup_l, d_oe}, a, d_out);
    end
    n_checks++;
    if ({req_ready, resp_valid, resp_nosel, resp_timeout} !== 4'b0000 || resp_rdata !== 8'h00) begin
      n_errors++; $display("FAIL rstmid_resp: got r/v/n/t=%b rd=%h want 0000/00",
        {req_ready, resp_valid, resp_nosel, resp_timeout}, resp_rdata);
    end
    chreset_l = 1'b1;
    cd_chrdy_l = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ext_clock);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || cmd !== 1'b1) seen_valid++;
    end
    n_checks++;
    if (seen_valid !== 0) begin n_errors++; $display("FAIL rstmid_no_resp: got %0d bad idle clocks want 0", seen_valid); end
  endtask

  task automatic test_back_to_back;
    int lat, ncmd, nadl, noe, nsu, nbad; logic rdy0, ns, to; logic [7:0] rd;
    do_cycle(1'b0, 1'b0, 16'h0388, 8'h21, 8'hC3, 1'b1, 0, 1'b1, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (lat !== 6 || nbad !== 0 || rd !== 8'hC3) begin
      n_errors++; $display("FAIL b2b_first_ignore: got lat=%0d bad=%0d rd=%h want 6/0/C3", lat, nbad, rd);
    end
    do_cycle(1'b1, 1'b0, 16'h0200, 8'h96, 8'hEE, 1'b1, 0, 1'b0, lat, ncmd, nadl, noe, nsu, nbad, rdy0, rd, ns, to);
    n_checks++;
    if (rdy0 !== 1'b1 || lat !== 6 || nbad !== 0 || noe !== 5 || rd !== 8'h00) begin
      n_errors++; $display("FAIL b2b_second: got rdy0=%b lat=%0d bad=%0d oe=%0d rd=%h want 1/6/0/5/00",
        rdy0, lat, nbad, noe, rd);
    end
    @(negedge ext_clock);
  endtask

  initial begin
    chreset_l = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_setup = 1'b0;
    req_addr = 16'h0000; req_wdata = 8'h00; d_in = 8'h00; cd_sfdbk = 1'b1; cd_chrdy_l = 1'b0;
    @(negedge ext_clock);
    test_reset();
    test_read();
    test_write();
    test_setup();
    test_chrdy_extend();
    test_timeout();
    test_nosel();
    test_reset_mid_cmd();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mca_cycle_master.md
MCA_CYCLE_MASTER -- requirements
Module: mca_cycle_master

Interface
REQ-001 SHALL provide parameter CMD_MIN, default 3: minimum cmd-low clocks per cycle.
REQ-002 SHALL provide parameter CHRDY_TIMEOUT, default 64: max cmd-low clocks before forced end.
REQ-003 ext_clock  in  1  sole clock, 14.318 MHz, all state on rising edge.
REQ-004 chreset_l  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  host requests one 8-bit I/O or POS cycle.
REQ-006 req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-007 req_write  in  1  1 = write cycle, 0 = read cycle.
REQ-008 req_setup  in  1  1 = POS setup cycle (cd_setup_l asserted).
REQ-009 req_addr  in  16  I/O address.
REQ-010 req_wdata  in  8  write data.
REQ-011 resp_valid  out  1  one-clock pulse at cycle completion.
REQ-012 resp_rdata  out  8  captured read data, held until next resp_valid; 0x00 for writes.
REQ-013 resp_nosel  out  1  non-setup cycle saw no cd_sfdbk; valid with resp_valid.
REQ-014 resp_timeout  out  1  cycle ended by CHRDY_TIMEOUT; valid with resp_valid.
REQ-015 adl_l  out  1  MCA address latch strobe, active-low.
REQ-016 cmd  out  1  MCA command strobe, active-low.
REQ-017 s0_w_l  out  1  MCA write status, active-low.
REQ-018 s1_r_l  out  1  MCA read status, active-low.
REQ-019 m_io  out  1  MCA memory/IO select; driven 0 during cycles, 1 in IDLE.
REQ-020 cd_setup_l  out  1  MCA card setup, active-low.
REQ-021 a  out  16  MCA address.
REQ-022 d_out  out  8  write data to external bus buffer.
REQ-023 d_oe  out  1  enables d_out onto bus.
REQ-024 d_in  in  8  bus data for reads.
REQ-025 cd_sfdbk  in  1  card-selected feedback, active-high.
REQ-026 cd_chrdy_l  in  1  channel ready; high = adapter extending cycle, low = ready.

Function
REQ-027 SHALL sequence IDLE -> ADDR (1 clk) -> ADL (1 clk) -> CMD (>= CMD_MIN clks) -> END (1 clk) -> IDLE; acceptance in IDLE moves to ADDR next clock.
REQ-028 ADDR..END: a=req_addr latched at accept; m_io=0; s0_w_l=~write, s1_r_l=write; cd_setup_l=~req_setup; all stable, changed only on accept or IDLE entry.
REQ-029 adl_l SHALL be 0 exactly in ADL; cmd SHALL be 0 exactly in CMD; both 1 elsewhere.
REQ-030 d_out=req_wdata latched at accept; d_oe=1 from ADL through END for writes, 0 always for reads.
REQ-031 nosel SHALL latch ~cd_sfdbk sampled at the last ADL clock when req_setup=0; forced 0 for setup cycles; cycle runs full length regardless.
REQ-032 CMD counter SHALL count cmd-low clocks from 1; CMD exits when count >= CMD_MIN and cd_chrdy_l=0, or count == CHRDY_TIMEOUT (timeout=1) -- timeout wins if both true.
REQ-033 Read data SHALL be captured from d_in on the final CMD clock (the edge cmd rises).
REQ-034 resp_valid SHALL pulse on the clock END -> IDLE, with rdata/nosel/timeout stable; req_ready rises same clock, so back-to-back requests incur one idle clock minimum.
REQ-035 req_valid and request fields SHALL be ignored outside IDLE; no queueing.

Reset
REQ-036 chreset_l=0 at a rising edge SHALL force IDLE next clock from any state, including mid-CMD: adl_l=1, cmd=1, s0_w_l=1, s1_r_l=1, m_io=1, cd_setup_l=1, a=0x0000, d_out=0x00, d_oe=0, req_ready=1 (after release), resp_valid=0, resp_rdata=0x00, resp_nosel=0, resp_timeout=0; no resp_valid for an aborted cycle.
REQ-037 req_ready SHALL be 0 while chreset_l=0.

Verification
REQ-038 Read 0x0388, cd_sfdbk=1, cd_chrdy_l=0, d_in=0xA5 -> ADDR1/ADL1/CMD3/END1, resp_rdata=0xA5, nosel=0, timeout=0, resp_valid 6 clocks after accept.
REQ-039 Write 0x0389 data 0x3C -> s0_w_l=0, d_oe=1 ADL..END, d_out=0x3C, resp_rdata=0x00, 6-clock latency.
REQ-040 Setup read 0x0100 with req_setup=1, cd_sfdbk=0, d_in=0xD7 -> cd_setup_l=0 ADDR..END, rdata=0xD7, nosel=0.
REQ-041 Read with cd_chrdy_l high for 10 CMD clocks then low -> cmd low 11 clocks, timeout=0; cd_chrdy_l stuck high -> cmd low exactly 64 clocks, timeout=1.
REQ-042 Read 0x0300 with cd_sfdbk=0 -> full cycle, nosel=1; chreset_l=0 during its CMD -> all outputs idle next clock, no resp_valid.
